mem_stage_ctrl: RTL and testbench

//  Consumer end of the EXE/MEM pipeline register. Takes the latched memory op (address, store data, read/write

---
 rtl/mem_stage_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the EXE/MEM memory op on a variable-latency req/ack bus,
// stalls upstream while the access is outstanding and registers the result into MEM/WB.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_nop,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [4:0]        in_reg_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_res,
  output logic [4:0]        wb_reg_dest,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              hold_reg_write_q, hold_reg_write_d;
  logic              hold_mem_to_reg_q, hold_mem_to_reg_d;
  logic [4:0]        hold_reg_dest_q, hold_reg_dest_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [DATA_W-1:0] wb_read_data_q, wb_read_data_d;
  logic [DATA_W-1:0] wb_alu_res_q, wb_alu_res_d;
  logic [4:0]        wb_reg_dest_q, wb_reg_dest_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic mem_op, aligned, launch, timeout_hit, m2r_eff;

  assign mem_op      = !in_nop && (in_mem_read || in_mem_write);
  assign aligned     = (in_address[1:0] == 2'b00);
  assign launch      = mem_op && aligned;
  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));
  // Read+write together behaves as a store, so WB must not select memory data.
  assign m2r_eff     = in_mem_to_reg && !(in_mem_read && in_mem_write);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    hold_reg_write_d  = hold_reg_write_q;
    hold_mem_to_reg_d = hold_mem_to_reg_q;
    hold_reg_dest_d   = hold_reg_dest_q;
    rdata_d           = rdata_q;
    wb_valid_d        = wb_valid_q;
    wb_reg_write_d    = wb_reg_write_q;
    wb_mem_to_reg_d   = wb_mem_to_reg_q;
    wb_read_data_d    = wb_read_data_q;
    wb_alu_res_d      = wb_alu_res_q;
    wb_reg_dest_d     = wb_reg_dest_q;
    misalign_d        = misalign_q;
    bus_err_d         = bus_err_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d           = BUSY;
          cnt_d             = '0;
          mem_we_d          = in_mem_write;
          mem_addr_d        = in_address;
          mem_wdata_d       = in_write_data;
          hold_reg_write_d  = in_reg_write;
          hold_mem_to_reg_d = m2r_eff;
          hold_reg_dest_d   = in_reg_dest;
          rdata_d           = '0;
          wb_valid_d        = 1'b0;
          wb_reg_write_d    = 1'b0;
        end else begin
          // Misaligned memory ops retire as valid but squashed (no register write).
          wb_valid_d      = !in_nop;
          wb_reg_write_d  = in_reg_write && !in_nop && !mem_op;
          wb_mem_to_reg_d = m2r_eff;
          wb_read_data_d  = '0;
          wb_alu_res_d    = in_address;
          wb_reg_dest_d   = in_reg_dest;
          if (mem_op) misalign_d = 1'b1;
        end
      end
      BUSY: begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        cnt_d          = cnt_q + TO_W'(1);
        if (mem_ack) begin
          rdata_d = mem_we_q ? '0 : mem_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          bus_err_d        = 1'b1;
          rdata_d          = '0;
          hold_reg_write_d = 1'b0;
          state_d          = DONE;
        end
      end
      DONE: begin
        wb_valid_d      = 1'b1;
        wb_reg_write_d  = hold_reg_write_q;
        wb_mem_to_reg_d = hold_mem_to_reg_q;
        wb_read_data_d  = rdata_q;
        wb_alu_res_d    = mem_addr_q;
        wb_reg_dest_d   = hold_reg_dest_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
      hold_reg_write_q  <= 1'b0;
      hold_mem_to_reg_q <= 1'b0;
      hold_reg_dest_q   <= '0;
      rdata_q           <= '0;
      wb_valid_q        <= 1'b0;
      wb_reg_write_q    <= 1'b0;
      wb_mem_to_reg_q   <= 1'b0;
      wb_read_data_q    <= '0;
      wb_alu_res_q      <= '0;
      wb_reg_dest_q     <= '0;
      misalign_q        <= 1'b0;
      bus_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      hold_reg_write_q  <= hold_reg_write_d;
      hold_mem_to_reg_q <= hold_mem_to_reg_d;
      hold_reg_dest_q   <= hold_reg_dest_d;
      rdata_q           <= rdata_d;
      wb_valid_q        <= wb_valid_d;
      wb_reg_write_q    <= wb_reg_write_d;
      wb_mem_to_reg_q   <= wb_mem_to_reg_d;
      wb_read_data_q    <= wb_read_data_d;
      wb_alu_res_q      <= wb_alu_res_d;
      wb_reg_dest_q     <= wb_reg_dest_d;
      misalign_q        <= misalign_d;
      bus_err_q         <= bus_err_d;
    end
  end

  // Stall is combinational, so gate it with rst to keep all outputs low during reset.
  assign stall         = !rst && ((state_q == BUSY) || ((state_q == IDLE) && launch));
  assign mem_req       = (state_q == BUSY);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_res    = wb_alu_res_q;
  assign wb_reg_dest   = wb_reg_dest_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random ops checked against a
// per-transaction model (latency, stall/req counts, WB contents, sticky errors).
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int TW = 3;

  logic          clk, rst;
  logic          in_nop, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
  logic [DW-1:0] in_address, in_write_data;
  logic [4:0]    in_reg_dest;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          stall, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [DW-1:0] wb_read_data, wb_alu_res;
  logic [4:0]    wb_reg_dest;
  logic          misalign_err, bus_err;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .TO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_nop(in_nop), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_address(in_address), .in_write_data(in_write_data), .in_reg_dest(in_reg_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res), .wb_reg_dest(wb_reg_dest),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_mis = 1'b0;
  logic exp_bus = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input logic nop, rd, wr, m2r, rw,
                          input logic [DW-1:0] addr, wd, input logic [4:0] dest);
    in_nop = nop; in_mem_read = rd; in_mem_write = wr; in_mem_to_reg = m2r;
    in_reg_write = rw; in_address = addr; in_write_data = wd; in_reg_dest = dest;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where WB shows the op.
  task automatic run_op(input logic nop, rd, wr, m2r, rw,
                        input logic [DW-1:0] addr, wd, input logic [4:0] dest,
                        input logic acked, input int k, input logic [DW-1:0] rdata);
    logic          mem_op, al, e_valid, e_rw, e_m2r, fin;
    logic [DW-1:0] e_rd;
    int            e_req, e_stall, e_lat, ke, cyc, n_req, n_stall;
    mem_op = !nop && (rd || wr);
    al     = (addr[1:0] == 2'b00);
    e_m2r  = m2r && !(rd && wr);
    if (mem_op && al) begin
      ke      = acked ? k : TO - 1;
      e_req   = ke + 1;
      e_stall = ke + 2;
      e_lat   = ke + 3;
      e_valid = 1'b1;
      e_rw    = acked ? rw : 1'b0;
      e_rd    = (acked && !wr) ? rdata : '0;
      if (!acked) exp_bus = 1'b1;
    end else begin
      e_req   = 0;
      e_stall = 0;
      e_lat   = 1;
      e_valid = !nop;
      e_rw    = rw && !nop && !mem_op;
      e_rd    = '0;
      if (mem_op) exp_mis = 1'b1;
    end
    drive_in(nop, rd, wr, m2r, rw, addr, wd, dest);
    cyc = 0; n_req = 0; n_stall = 0; fin = 1'b0;
    while (!fin && cyc < 40) begin
      #1;
      if (stall) n_stall++;
      if (mem_req) begin
        chk("mem_we", mem_we, wr);
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, wd);
        mem_ack   = acked && (n_req == k);
        mem_rdata = mem_ack ? rdata : $urandom;
        n_req++;
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      fin = !stall;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!fin) begin
        chk("bubble_valid", wb_valid, 1'b0);
        chk("bubble_rw", wb_reg_write, 1'b0);
      end
    end
    mem_ack = 1'b0;
    chk("latency", cyc, e_lat);
    chk("stall_cycles", n_stall, e_stall);
    chk("req_cycles", n_req, e_req);
    chk("wb_valid", wb_valid, e_valid);
    chk("wb_reg_write", wb_reg_write, e_rw);
    if (e_valid) begin
      chk("wb_mem_to_reg", wb_mem_to_reg, e_m2r);
      chk("wb_read_data", wb_read_data, e_rd);
      chk("wb_alu_res", wb_alu_res, addr);
      chk("wb_reg_dest", wb_reg_dest, dest);
    end
    chk("misalign_err", misalign_err, exp_mis);
    chk("bus_err", bus_err, exp_bus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic          rd, wr, nop, acked;
    logic [DW-1:0] addr;
    int            ty;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd1);
    #12;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rw", wb_reg_write, 1'b0);
    chk("rst_wb_alu", wb_alu_res, '0);
    chk("rst_errs", {misalign_err, bus_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 1'b0, 0, 32'h0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7, 1'b1, 2, 32'hDEADBEEF);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hA5A5A5A5, 5'd0, 1'b1, 0, 32'h0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd3, 1'b0, 0, 32'h0);
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 32'h1111, 5'd4, 1'b1, TO - 1, 32'h55);

    // Reset in the middle of a BUSY access, then an ack that must be ignored.
    drive_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 5'd2);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("busy_before_rst", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_req", mem_req, 1'b0);
    chk("rst_busy_stall", stall, 1'b0);
    chk("rst_busy_wb", {wb_valid, wb_reg_write}, 2'b00);
    chk("rst_busy_errs", {misalign_err, bus_err}, 2'b00);
    chk("rst_busy_addr", mem_addr, '0);
    exp_mis = 1'b0; exp_bus = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk("post_rst_req", mem_req, 1'b0);
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_wb", wb_valid, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ty    = $urandom_range(0, 5);
      nop   = (ty == 0);
      rd    = (ty == 2 || ty == 4) || (nop && $urandom_range(0, 1) == 1);
      wr    = (ty == 3 || ty == 4) || (nop && $urandom_range(0, 1) == 1);
      addr  = $urandom;
      if (ty == 5) begin
        rd = $urandom_range(0, 1) == 1;
        wr = !rd;
        if (addr[1:0] == 2'b00) addr[0] = 1'b1;
      end else if (ty >= 2) begin
        addr[1:0] = 2'b00;
      end
      acked = ($urandom_range(0, 4) != 0);
      run_op(nop, rd, wr, 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom),
             acked, $urandom_range(0, TO - 1), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
